// File: rtl/msg_pkg.sv
// Shared types and helpers for the message serializer.
package msg_pkg;

  // Default configuration: 32-byte messages carried on 8-byte beats.
  localparam int DEF_MAX_MSG_BYTES = 32;
  localparam int DEF_DATA_BYTES    = 8;
  localparam int DEF_TKEEP_WIDTH   = 8;

  // Longest burst in beats and the width needed to count it without wrapping.
  localparam int MAX_BEATS  = (DEF_MAX_MSG_BYTES + DEF_DATA_BYTES - 1) / DEF_DATA_BYTES;
  localparam int BEAT_CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Byte enables with the low 'rem' bits set, contiguous from the LSB.
  function automatic logic [DEF_TKEEP_WIDTH-1:0] keep_mask(
    input logic [$clog2(DEF_TKEEP_WIDTH):0] rem
  );
    logic [DEF_TKEEP_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < DEF_TKEEP_WIDTH; i++) begin
      if (int'(rem) > i) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/msg_serializer_axi_master.sv
// AXI-Stream master output stage: registered beat with stall hold.
module axi_master #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic              in_user,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tuser
);

  // Take a new beat only when the register is empty or the slave is taking the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= 1'b0;
    end else if (!m_tvalid || m_tready) begin
      m_tvalid <= load;
      m_tlast  <= load && in_last;
      m_tdata  <= load ? in_data : '0;
      m_tkeep  <= load ? in_keep : '0;
      m_tuser  <= load && in_user;
    end
  end

endmodule

// File: rtl/msg_serializer.sv
// Serializes one whole message per handshake into an AXI-Stream burst.
module msg_serializer
  import msg_pkg::*;
#(
  parameter int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
  parameter int DATA_BYTES    = DEF_DATA_BYTES,
  parameter int TKEEP_WIDTH   = DEF_TKEEP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [15:0]                msg_length,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic                       msg_error,
  output logic                       msg_drop,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [8*DATA_BYTES-1:0]    m_tdata,
  output logic [TKEEP_WIDTH-1:0]     m_tkeep,
  output logic                       m_tuser
);

  localparam int MSG_W  = 8 * MAX_MSG_BYTES;
  localparam int BEAT_W = 8 * DATA_BYTES;
  localparam int NBEATS = (MAX_MSG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam int IDX_W  = $clog2(DATA_BYTES);

  state_t                 state;
  logic [MSG_W-1:0]       shreg;
  logic [CNT_W-1:0]       beats_left;
  logic [TKEEP_WIDTH-1:0] last_keep;
  logic                   err_flag;

  logic                   clamp;
  logic                   zero_len;
  logic [15:0]            len_eff;
  logic [MSG_W-1:0]       masked;
  logic [CNT_W-1:0]       in_beats;
  logic [TKEEP_WIDTH-1:0] in_last_keep;
  logic                   accept;
  logic                   advance;

  logic                   load;
  logic [BEAT_W-1:0]      beat_data;
  logic [TKEEP_WIDTH-1:0] beat_keep;
  logic                   beat_last;
  logic                   beat_user;

  assign clamp        = msg_length > 16'(MAX_MSG_BYTES);
  assign zero_len     = msg_length == 16'd0;
  assign len_eff      = clamp ? 16'(MAX_MSG_BYTES) : msg_length;
  assign in_beats     = CNT_W'((len_eff + 16'(DATA_BYTES - 1)) >> IDX_W);
  assign in_last_keep = (len_eff[IDX_W-1:0] == '0) ? '1
                                                   : keep_mask({1'b0, len_eff[IDX_W-1:0]});

  // Ready when idle, or when the final beat is leaving this cycle so the next message follows with no gap.
  assign msg_ready = rst && ((state == IDLE) || (state == SEND && m_tlast && m_tready));
  assign accept    = msg_valid && msg_ready;
  assign advance   = (state == SEND) && m_tready;

  // Zero every byte past the effective length so the tail of the last beat reads as 0.
  always_comb begin
    masked = '0;
    for (int i = 0; i < MAX_MSG_BYTES; i++) begin
      if (16'(i) < len_eff) masked[8*i +: 8] = msg_data[8*i +: 8];
    end
  end

  // Pick the next beat: the first beat comes straight from the input, later ones from the shift register.
  always_comb begin
    load      = 1'b0;
    beat_data = shreg[BEAT_W-1:0];
    beat_keep = '1;
    beat_last = 1'b0;
    beat_user = 1'b0;
    if (accept && !zero_len) begin
      load      = 1'b1;
      beat_data = masked[BEAT_W-1:0];
      beat_last = in_beats == CNT_W'(1);
      beat_keep = beat_last ? in_last_keep : '1;
      beat_user = beat_last && (msg_error || clamp);
    end else if (advance && !m_tlast) begin
      load      = 1'b1;
      beat_last = beats_left == CNT_W'(1);
      beat_keep = beat_last ? last_keep : '1;
      beat_user = beat_last && err_flag;
    end
  end

  // Message FSM: capture on accept, shift out one beat per handshake, leave on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      beats_left <= '0;
      last_keep  <= '0;
      err_flag   <= 1'b0;
      msg_drop   <= 1'b0;
    end else begin
      msg_drop <= accept && zero_len;
      if (accept && !zero_len) begin
        state      <= SEND;
        shreg      <= masked >> BEAT_W;
        beats_left <= in_beats - CNT_W'(1);
        last_keep  <= in_last_keep;
        err_flag   <= msg_error || clamp;
      end else if (advance) begin
        if (m_tlast) begin
          state <= IDLE;
        end else begin
          shreg      <= shreg >> BEAT_W;
          beats_left <= beats_left - CNT_W'(1);
        end
      end
    end
  end

  axi_master #(
    .DATA_W(BEAT_W),
    .KEEP_W(TKEEP_WIDTH)
  ) u_axi_master (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in_data  (beat_data),
    .in_keep  (beat_keep),
    .in_last  (beat_last),
    .in_user  (beat_user),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tuser  (m_tuser)
  );

endmodule

// File: tb/tb_msg_serializer.sv
// Scoreboard bench for msg_serializer: expected beats queued by stimulus, checked by a monitor.
module tb_msg_serializer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [15:0]  msg_length = '0;
  logic [255:0] msg_data = '0;
  logic         msg_error = 1'b0;
  logic         msg_drop;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tuser;

  beat_t exp_q[$];
  logic  tready_q[$];
  int    checks = 0;
  int    errors = 0;
  int    drop_count = 0;

  msg_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_length (msg_length),
    .msg_data   (msg_data),
    .msg_error  (msg_error),
    .msg_drop   (msg_drop),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tuser    (m_tuser)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectBeat(input logic [63:0] data, input logic [7:0] keep, input logic last, input logic user);
    beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = last;
    b.user = user;
    exp_q.push_back(b);
  endtask

  // Present a message and return just after the clock edge that accepts it.
  task automatic applyStimulus(input logic [15:0] len, input logic err);
    bit done = 0;
    @(negedge clk);
    #1;
    msg_length = len;
    msg_error  = err;
    msg_valid  = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (msg_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept for len=%0d", len);
    end
  endtask

  task automatic releaseMsg();
    @(negedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !m_tvalid) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  // Ready pattern driver: plays queued values, otherwise keeps the slave ready.
  initial begin
    forever begin
      @(negedge clk);
      if (tready_q.size() != 0) m_tready = tready_q.pop_front();
      else m_tready = 1'b1;
    end
  end

  // Monitor: compare every presented beat with the queue head, pop it on handshake.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && m_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got tdata 0x%0h, expected no beat", m_tdata);
        end else begin
          e = exp_q[0];
          checkOutput("tdata", m_tdata, e.data);
          checkOutput("tkeep", 64'(m_tkeep), 64'(e.keep));
          checkOutput("tlast", 64'(m_tlast), 64'(e.last));
          checkOutput("tuser", 64'(m_tuser), 64'(e.user));
          if (!m_tready) checkOutput("msg_ready_stall", 64'(msg_ready), 64'd0);
          else void'(exp_q.pop_front());
        end
      end
      if (rst && msg_drop) drop_count++;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) msg_data[8*i +: 8] = 8'(i);

    // Reset state
    #12;
    checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst_tuser", 64'(m_tuser), 64'd0);
    checkOutput("rst_tdata", m_tdata, 64'd0);
    checkOutput("rst_tkeep", 64'(m_tkeep), 64'd0);
    checkOutput("rst_drop", 64'(msg_drop), 64'd0);
    checkOutput("rst_msg_ready", 64'(msg_ready), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // len=20: three beats, partial last
    expectBeat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0000000013121110, 8'h0F, 1'b1, 1'b0);
    applyStimulus(16'd20, 1'b0);
    releaseMsg();
    waitDrain();

    // len=16 with error flag
    expectBeat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 1'b1);
    applyStimulus(16'd16, 1'b1);
    releaseMsg();
    waitDrain();

    // len=20 under back-pressure
    expectBeat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0000000013121110, 8'h0F, 1'b1, 1'b0);
    applyStimulus(16'd20, 1'b0);
    tready_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    releaseMsg();
    waitDrain();

    // len=40 clamps to 32 bytes and flags tuser
    expectBeat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h1716151413121110, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h1F1E1D1C1B1A1918, 8'hFF, 1'b1, 1'b1);
    applyStimulus(16'd40, 1'b0);
    releaseMsg();
    waitDrain();

    // len=0 is swallowed with a single drop pulse
    applyStimulus(16'd0, 1'b0);
    releaseMsg();
    repeat (3) @(negedge clk);
    #3;
    checkOutput("drop_count", 64'(drop_count), 64'd1);
    checkOutput("idle_after_drop", 64'(msg_ready), 64'd1);
    checkOutput("no_beat_after_drop", 64'(m_tvalid), 64'd0);

    // Back-to-back len=8 then len=12
    expectBeat(64'h0706050403020100, 8'hFF, 1'b1, 1'b0);
    expectBeat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h000000000B0A0908, 8'h0F, 1'b1, 1'b0);
    applyStimulus(16'd8, 1'b0);
    applyStimulus(16'd12, 1'b0);
    releaseMsg();
    @(negedge clk);
    #3;
    checkOutput("b2b_no_gap_tvalid", 64'(m_tvalid), 64'd1);
    checkOutput("b2b_second_last", 64'(m_tlast), 64'd1);
    waitDrain();

    // Reset during beat 2 of a 32-byte message
    expectBeat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    expectBeat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
    applyStimulus(16'd32, 1'b0);
    releaseMsg();
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("midrst_tlast", 64'(m_tlast), 64'd0);
    checkOutput("midrst_msg_ready", 64'(msg_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    expectBeat(64'h0706050403020100, 8'hFF, 1'b1, 1'b0);
    applyStimulus(16'd8, 1'b0);
    releaseMsg();
    waitDrain();

    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("final_drop_count", 64'(drop_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msg_serializer.md
Name: msg_serializer

Overview:
- Transmit-side counterpart of the message parser.
- Accepts one complete message (up to MAX_MSG_BYTES bytes, LSB at [0]) per handshake and emits it as an AXI-Stream master burst of DATA_BYTES-wide beats.
- Drives tkeep, tlast and tuser (error flag) on the outgoing stream.
- Sits between message-producing logic and any AXI-ST slave, including msg_parser for loopback.

Parameters:
- MAX_MSG_BYTES, 32, maximum message size in bytes; width of msg_data is 8*MAX_MSG_BYTES.
- DATA_BYTES, 8, stream beat width in bytes.
- TKEEP_WIDTH, 8, tkeep width; must equal DATA_BYTES.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- msg_valid  in  1  message presented.
- msg_ready  out  1  message accepted when msg_valid && msg_ready.
- msg_length  in  16  message length in bytes.
- msg_data  in  8*MAX_MSG_BYTES  message payload, byte 0 at [7:0].
- msg_error  in  1  message carries an error; forwarded on tuser.
- msg_drop  out  1  one-cycle pulse when a zero-length message is accepted and discarded.
- m_tvalid  out  1  AXI-ST valid.
- m_tready  in  1  AXI-ST ready.
- m_tlast  out  1  last beat of message.
- m_tdata  out  8*DATA_BYTES  beat data.
- m_tkeep  out  TKEEP_WIDTH  byte enables, contiguous from LSB.
- m_tuser  out  1  error flag, meaningful only when m_tlast=1.

Behaviour:
- Reset (rst=0, async): state=IDLE; m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, m_tkeep=0, msg_drop=0. msg_ready=0 while rst=0.
- States:
  - IDLE: msg_ready=1.
  - SEND: outputs registered, m_tvalid=1.
- IDLE + accept with len>0: capture payload into shift register, compute beats=ceil(min(len,MAX_MSG_BYTES)/DATA_BYTES), go to SEND. First beat on m_tvalid one cycle after accept (latency 1).
- Beat k carries msg_data[8*DATA_BYTES*k +: 8*DATA_BYTES]. Non-last beats: tkeep all ones, tlast=0, tuser=0.
- Last beat: tlast=1; tkeep = low (len mod DATA_BYTES) bits set, or all ones if the remainder is 0. Bytes beyond length in tdata are driven 0.
- m_tuser on last beat = captured msg_error OR clamp flag.
- Clamp: len>MAX_MSG_BYTES is treated as MAX_MSG_BYTES bytes and sets the clamp flag.
- Zero length: accepted, no beats emitted, msg_drop pulses the cycle after accept, state stays IDLE.
- AXI rule: while m_tvalid=1 && m_tready=0, all m_* outputs hold stable. Advance only on m_tvalid && m_tready.
- Back-to-back: msg_ready is also 1 in SEND when the current beat is last and m_tready=1 (combinational from m_tready). An accept in that cycle loads the next message, giving zero idle cycles between bursts. Otherwise the block returns to IDLE with m_tvalid=0.
- Beat counter width: $clog2(ceil(MAX_MSG_BYTES/DATA_BYTES)+1). No wrap: SEND exits on the last-beat handshake.
- Reset mid-burst: the burst is abandoned immediately with no tlast. The next message after reset starts clean.
- msg_valid while msg_ready=0 is ignored; the producer must hold it.

Decomposition:
- Package msg_pkg:
  - MAX_BEATS, BEAT_CNT_W constants.
  - state enum typedef {IDLE, SEND}.
  - Function keep_mask(rem), returning the TKEEP_WIDTH-bit LSB-contiguous mask.
- One natural sub-module, axi_master: owns the m_tvalid/m_tready output register and stall-hold logic, mirroring axi_slave.
- The top holds the shift register, beat counter and FSM.

Test Plan:
- len=20, DATA_BYTES=8, bytes 0x00..0x13, m_tready=1 -> 3 beats. tkeep FF,FF,0F; tlast on beat 3 only; beat 3 tdata=0x0000000013121110; tuser=0.
- len=16, msg_error=1 -> 2 beats, tkeep FF,FF, tlast+tuser=1 on beat 2 only.
- len=20, m_tready toggling 1,0,0,1,0,1 -> beats never duplicated or skipped; outputs stable during stalls; msg_ready=0 throughout.
- len=40 (>32) -> 4 full beats (tkeep FF each), tuser=1 on last. Then len=0 -> no beats, msg_drop one pulse.
- Two messages len=8 then len=12, msg_valid held, m_tready=1 -> beats on consecutive cycles with no gap; tlast on cycles 1 and 3; second tkeep FF,0F.
- rst asserted during beat 2 of a 32-byte message -> m_tvalid=0 asynchronously. After release, a len=8 message emits one beat, tkeep FF, tlast=1.
